// File: rtl/mem_display_sequencer_pkg.sv
// Shared definitions for the memory display sequencer.
// Holds the state encoding, the default display parameters and the address
// stepping helper. It is imported by the top level.
package mem_display_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FETCH = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_t;

  localparam logic [15:0] DWELL_DEFAULT     = 16'd1000;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_0004;
  localparam logic [31:0] STEP_DEFAULT      = 32'h0000_0004;
  localparam logic [31:0] LAST_ADDR_DEFAULT = 32'h0000_003C;

  // Next word address in the display walk, wrapping from last back to base.
  // Arithmetic is plain 32-bit modulo.
  function automatic logic [31:0] next_disp_addr(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [31:0] step,
    input logic [31:0] last
  );
    return (addr == last) ? base : addr + step;
  endfunction

endpackage

// File: rtl/mem_display_sequencer_finish_sync.sv
// finish_sync: brings the asynchronous "execution finished" button level
// into the clk domain and produces a one-cycle pulse on its rising edge.
// Ports:
//   clk          system clock
//   reset        synchronous reset, active low
//   finish       asynchronous level from the button
//   finish_pulse one-cycle pulse on the synchronised rising edge
module finish_sync (
  input  logic clk,
  input  logic reset,
  input  logic finish,
  output logic finish_pulse
);

  logic sync_q1;
  logic sync_q2;
  logic sync_q3;

  // sync_q1/sync_q2 form the metastability chain; sync_q3 only remembers the
  // previous synchronised value for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      sync_q3 <= 1'b0;
    end else begin
      sync_q1 <= finish;
      sync_q2 <= sync_q1;
      sync_q3 <= sync_q2;
    end
  end

  assign finish_pulse = sync_q2 & ~sync_q3;

endmodule

// File: rtl/mem_display_sequencer.sv
// mem_display_sequencer: shares the data memory port between the CPU and a
// display walker. While the CPU runs, its bus passes straight through. After
// the finish button, the last CPU write is allowed to drain, then the block
// takes the port and shows one memory word at a time on the 4-digit display,
// dwelling DWELL tick_1k pulses per word and wrapping LAST_ADDR -> BASE_ADDR.
//
// Ports:
//   clk, reset                       clock, synchronous active-low reset
//   tick_1k                          1 kHz one-cycle enable
//   finish                           asynchronous button level
//   cpu_mem_read/write, cpu_addr,
//   cpu_wdata                        CPU bus request
//   mem_rdata                        memory read data (same-cycle)
//   mem_read/write, mem_addr,
//   mem_wdata                        memory port
//   cpu_grant                        1 while the CPU owns the memory port
//   disp_word, disp_valid            captured word for the digit scanner
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | CPU owns memory, bus passed through combinationally
// ST_DRAIN | finish seen; CPU keeps the port only while it is still writing
// ST_FETCH | one-cycle read of disp_addr, capture low 16 bits for display
// ST_HOLD  | keep showing the word, count tick_1k until the dwell expires
module mem_display_sequencer
  import mem_display_sequencer_pkg::*;
#(
  parameter logic [15:0] DWELL     = DWELL_DEFAULT,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter logic [31:0] STEP      = STEP_DEFAULT,
  parameter logic [31:0] LAST_ADDR = LAST_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1k,
  input  logic        finish,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_grant,
  output logic [15:0] disp_word,
  output logic        disp_valid
);

  seq_state_t  state;
  seq_state_t  state_next;
  logic [31:0] disp_addr;
  logic [31:0] disp_addr_next;
  logic [15:0] dwell_cnt;
  logic [15:0] dwell_cnt_next;
  logic [15:0] disp_word_next;
  logic        disp_valid_next;
  logic        finish_pulse;

  // Only the low half of a word is displayed.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^mem_rdata[31:16];

  finish_sync u_finish_sync (
    .clk          (clk),
    .reset        (reset),
    .finish       (finish),
    .finish_pulse (finish_pulse)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_RUN;
      disp_addr  <= BASE_ADDR;
      dwell_cnt  <= '0;
      disp_word  <= '0;
      disp_valid <= 1'b0;
    end else begin
      state      <= state_next;
      disp_addr  <= disp_addr_next;
      dwell_cnt  <= dwell_cnt_next;
      disp_word  <= disp_word_next;
      disp_valid <= disp_valid_next;
    end
  end

  always_comb begin
    state_next      = state;
    disp_addr_next  = disp_addr;
    dwell_cnt_next  = dwell_cnt;
    disp_word_next  = disp_word;
    disp_valid_next = disp_valid;
    cpu_grant       = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_addr        = disp_addr;
    mem_wdata       = '0;

    case (state)
      ST_RUN: begin
        cpu_grant = 1'b1;
        if (finish_pulse) begin
          state_next = ST_DRAIN;
        end
      end

      // Every exit from DRAIN starts the walk at BASE_ADDR, so a further
      // finish pulse here needs no extra handling.
      ST_DRAIN: begin
        if (cpu_mem_write) begin
          cpu_grant = 1'b1;
        end else begin
          mem_addr       = BASE_ADDR;
          disp_addr_next = BASE_ADDR;
          dwell_cnt_next = '0;
          state_next     = ST_FETCH;
        end
      end

      ST_FETCH: begin
        mem_read = 1'b1;
        if (finish_pulse) begin
          disp_addr_next = BASE_ADDR;
          dwell_cnt_next = '0;
        end else begin
          disp_word_next  = mem_rdata[15:0];
          disp_valid_next = 1'b1;
          dwell_cnt_next  = '0;
          state_next      = ST_HOLD;
        end
      end

      ST_HOLD: begin
        mem_read = 1'b1;
        if (finish_pulse) begin
          disp_addr_next = BASE_ADDR;
          dwell_cnt_next = '0;
          state_next     = ST_FETCH;
        end else if (tick_1k) begin
          if (dwell_cnt == DWELL - 16'd1) begin
            disp_addr_next = next_disp_addr(disp_addr, BASE_ADDR, STEP, LAST_ADDR);
            dwell_cnt_next = '0;
            state_next     = ST_FETCH;
          end else begin
            dwell_cnt_next = dwell_cnt + 16'd1;
          end
        end
      end

      default: begin
        state_next = ST_RUN;
      end
    endcase

    // The CPU bus is a pure combinational pass-through whenever it is granted.
    if (cpu_grant) begin
      mem_read  = cpu_mem_read;
      mem_write = cpu_mem_write;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

endmodule

// File: tb/tb_mem_display_sequencer.sv
module tb_mem_display_sequencer;

  localparam int          NWORDS  = 16;
  localparam int          NSHOW   = 15;
  localparam int          DWELL_T = 1000;
  localparam logic [31:0] BASE_T  = 32'h4;
  localparam logic [31:0] STEP_T  = 32'h4;

  localparam int MD_CPU   = 0;
  localparam int MD_DRAIN = 1;
  localparam int MD_FETCH = 2;
  localparam int MD_SHOW  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick_1k = 1'b0;
  logic        finish = 1'b0;
  logic        cpu_mem_read = 1'b0;
  logic        cpu_mem_write = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_grant;
  logic [15:0] disp_word;
  logic        disp_valid;

  int n_total = 0;
  int n_bad   = 0;

  mem_display_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .tick_1k       (tick_1k),
    .finish        (finish),
    .cpu_mem_read  (cpu_mem_read),
    .cpu_mem_write (cpu_mem_write),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .mem_rdata     (mem_rdata),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .cpu_grant     (cpu_grant),
    .disp_word     (disp_word),
    .disp_valid    (disp_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0101;
  endfunction

  // Memory stub driven by the DUT's port.
  logic [31:0] stub_mem [NWORDS];
  logic        mem_init_done = 1'b0;
  assign mem_rdata = stub_mem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < NWORDS; i++) stub_mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else if (mem_write) begin
      stub_mem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  // Behavioural reference: which party owns memory, which word index of the
  // walk is on show, how many ticks it has been shown, and the finish
  // samples seen at the last three edges.
  int          m_mode;
  int          m_idx;
  int          m_ticks;
  logic [15:0] m_word;
  logic        m_valid;
  logic [31:0] model_mem [NWORDS];
  logic        fin_hist [3];

  function automatic logic [31:0] show_addr(input int idx);
    return BASE_T + STEP_T * 32'(idx);
  endfunction

  task automatic model_update();
    logic        p;
    logic [31:0] a;
    p = fin_hist[1] & ~fin_hist[2];
    if (!reset) begin
      m_mode = MD_CPU; m_idx = 0; m_ticks = 0; m_word = '0; m_valid = 1'b0;
      fin_hist[0] = 1'b0; fin_hist[1] = 1'b0; fin_hist[2] = 1'b0;
      return;
    end
    case (m_mode)
      MD_CPU: begin
        if (cpu_mem_write) model_mem[cpu_addr[5:2]] = cpu_wdata;
        if (p) m_mode = MD_DRAIN;
      end
      MD_DRAIN: begin
        if (cpu_mem_write) model_mem[cpu_addr[5:2]] = cpu_wdata;
        else begin m_mode = MD_FETCH; m_idx = 0; m_ticks = 0; end
      end
      MD_FETCH: begin
        if (p) begin
          m_idx = 0; m_ticks = 0;
        end else begin
          a = show_addr(m_idx);
          m_word = model_mem[a[5:2]][15:0];
          m_valid = 1'b1; m_ticks = 0; m_mode = MD_SHOW;
        end
      end
      default: begin
        if (p) begin
          m_idx = 0; m_ticks = 0; m_mode = MD_FETCH;
        end else if (tick_1k) begin
          m_ticks++;
          if (m_ticks == DWELL_T) begin
            m_idx = (m_idx + 1) % NSHOW; m_ticks = 0; m_mode = MD_FETCH;
          end
        end
      end
    endcase
    fin_hist[2] = fin_hist[1];
    fin_hist[1] = fin_hist[0];
    fin_hist[0] = finish;
  endtask

  task automatic check_model(input string tag);
    logic        own, e_rd, e_wr;
    logic [31:0] e_addr;
    bit          ok;
    own = (m_mode == MD_CPU) || (m_mode == MD_DRAIN && cpu_mem_write);
    if (own) begin
      e_rd = cpu_mem_read; e_wr = cpu_mem_write; e_addr = cpu_addr;
    end else if (m_mode == MD_DRAIN) begin
      e_rd = 1'b0; e_wr = 1'b0; e_addr = '0;
    end else begin
      e_rd = 1'b1; e_wr = 1'b0; e_addr = show_addr(m_idx);
    end
    ok = (cpu_grant === own) && (mem_read === e_rd) && (mem_write === e_wr) &&
         (disp_word === m_word) && (disp_valid === m_valid);
    if (own || e_rd) ok = ok && (mem_addr === e_addr);
    if (own) ok = ok && (mem_wdata === cpu_wdata);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL model_%s t=%0t got grant=%b rd=%b wr=%b addr=%h word=%h valid=%b want grant=%b rd=%b wr=%b addr=%h word=%h valid=%b",
               tag, $time, cpu_grant, mem_read, mem_write, mem_addr, disp_word, disp_valid,
               own, e_rd, e_wr, e_addr, m_word, m_valid);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called with inputs already set after a falling edge.
  task automatic cycle(input string tag);
    #1;
    check_model(tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic cpu_noise();
    cpu_mem_write = 1'($urandom_range(0, 1));
    cpu_mem_read  = 1'($urandom_range(0, 1));
    cpu_addr      = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    cpu_wdata     = $urandom;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1k = 1'b1; cpu_noise(); cycle("tick");
      tick_1k = 1'b0; cpu_noise(); cycle("idle");
    end
  endtask

  task automatic check_memory(input string name);
    for (int i = 0; i < NWORDS; i++) chk(name, stub_mem[i], model_mem[i]);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_rd;
    logic        e_wr;
    logic        e_gr;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h08, 32'h0000_1234, 1'b0, 1'b1, 1'b1, 32'h08, 32'h0000_1234};
    vecs[1] = '{1'b1, 1'b0, 32'h08, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h08, 32'h0000_0000};
    vecs[2] = '{1'b0, 1'b1, 32'h04, 32'h0000_ABCD, 1'b0, 1'b1, 1'b1, 32'h04, 32'h0000_ABCD};
    vecs[3] = '{1'b1, 1'b0, 32'h3C, 32'hFFFF_0000, 1'b1, 1'b0, 1'b1, 32'h3C, 32'hFFFF_0000};
    vecs[4] = '{1'b0, 1'b1, 32'h3C, 32'h0000_5A5A, 1'b0, 1'b1, 1'b1, 32'h3C, 32'h0000_5A5A};
    vecs[5] = '{1'b0, 1'b0, 32'h10, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0000_0000};

    for (int i = 0; i < NWORDS; i++) model_mem[i] = init_word(i);

    reset = 1'b0;
    repeat (2) begin
      @(posedge clk);
      model_update();
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_grant", 32'(cpu_grant), 32'd1);
    chk("rst_valid", 32'(disp_valid), 32'd0);
    chk("rst_word", 32'(disp_word), 32'd0);
    cycle("post_reset");

    // CPU pass-through in RUN
    for (int i = 0; i < 6; i++) begin
      cpu_mem_read = vecs[i].rd; cpu_mem_write = vecs[i].wr;
      cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
      #1;
      n_total++;
      if ({mem_read, mem_write, cpu_grant, mem_addr, mem_wdata} !==
          {vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_gr, vecs[i].e_addr, vecs[i].e_wdata}) begin
        n_bad++;
        $display("FAIL run_vec%0d: got rd=%b wr=%b grant=%b addr=%h wdata=%h want rd=%b wr=%b grant=%b addr=%h wdata=%h",
                 i, mem_read, mem_write, cpu_grant, mem_addr, mem_wdata, vecs[i].e_rd, vecs[i].e_wr,
                 vecs[i].e_gr, vecs[i].e_addr, vecs[i].e_wdata);
      end
      cycle("run_vec");
    end

    // finish rises during a 3-cycle CPU write
    cpu_mem_read = 1'b0; cpu_mem_write = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h0000_0077;
    finish = 1'b1;
    repeat (3) cycle("drain_write");
    cpu_mem_write = 1'b0;
    #1;
    chk("drain_grant_drop", 32'(cpu_grant), 32'd0);
    chk("drain_no_write", 32'(mem_write), 32'd0);
    cycle("drain_exit");
    chk("fetch_addr_base", mem_addr, 32'h4);
    chk("fetch_read", 32'(mem_read), 32'd1);
    chk("drain_write_landed", stub_mem[4], 32'h0000_0077);
    cycle("fetch");
    chk("hold_word_abcd", 32'(disp_word), 32'h0000_ABCD);
    chk("hold_valid", 32'(disp_valid), 32'd1);

    // first dwell with CPU noise on the bus
    do_ticks(DWELL_T);
    chk("second_addr", mem_addr, 32'h8);
    chk("second_word", 32'(disp_word), 32'h0000_1234);

    // walk to the last word, then wrap
    do_ticks(13 * DWELL_T);
    chk("last_addr", mem_addr, 32'h3C);
    chk("last_word", 32'(disp_word), 32'h0000_5A5A);
    do_ticks(DWELL_T);
    chk("wrap_addr", mem_addr, 32'h4);
    chk("wrap_word", 32'(disp_word), 32'h0000_ABCD);
    check_memory("hold_mem_unchanged");

    // one-cycle reset during HOLD
    do_ticks(5);
    cpu_mem_write = 1'b0; cpu_mem_read = 1'b1; cpu_addr = 32'h20;
    reset = 1'b0;
    cycle("reset_pulse");
    reset = 1'b1;
    #1;
    chk("rst_hold_grant", 32'(cpu_grant), 32'd1);
    chk("rst_hold_valid", 32'(disp_valid), 32'd0);
    chk("rst_hold_word", 32'(disp_word), 32'd0);
    chk("rst_hold_addr", mem_addr, 32'h20);
    cycle("after_reset");

    // randomized traffic, finish toggles, ticks and rare resets
    for (int c = 0; c < 6000; c++) begin
      cpu_noise();
      tick_1k = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) finish = ~finish;
      reset = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      cycle("random");
    end
    reset = 1'b1;
    cpu_mem_write = 1'b0;
    cycle("final");
    check_memory("final_mem");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_display_sequencer.md
MEM_DISPLAY_SEQUENCER -- requirements
Module: mem_display_sequencer

Interface
REQ-001 SHALL have parameter DWELL, default 16'd1000, tick_1k pulses each word stays displayed (1 s).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h00000004, first word address shown after finish.
REQ-003 SHALL have parameter STEP, default 32'h00000004, address increment between displayed words.
REQ-004 SHALL have parameter LAST_ADDR, default 32'h0000003C, last word address shown before wrapping to BASE_ADDR.
REQ-005 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-007 SHALL have port tick_1k  input  1  one-clk-wide enable pulse at 1 kHz, already in clk domain.
REQ-008 SHALL have port finish  input  1  asynchronous level from button, CPU execution finished.
REQ-009 SHALL have ports cpu_mem_read, cpu_mem_write  input  1 each  CPU bus strobes.
REQ-010 SHALL have ports cpu_addr, cpu_wdata  input  32 each  CPU bus address and write data.
REQ-011 SHALL have port mem_rdata  input  32  data memory read data, valid in the same cycle as mem_addr.
REQ-012 SHALL have ports mem_read, mem_write  output  1 each  strobes to data memory.
REQ-013 SHALL have ports mem_addr, mem_wdata  output  32 each  address and write data to data memory.
REQ-014 SHALL have port cpu_grant  output  1  1 while the CPU owns the memory port.
REQ-015 SHALL have port disp_word  output  16  registered value for the 4-digit scanner (mem_rdata[15:0]).
REQ-016 SHALL have port disp_valid  output  1  1 while disp_word holds a valid captured word.

Function
REQ-017 SHALL synchronise finish with two flops and act only on its synchronised rising edge (finish_pulse).
REQ-018 SHALL implement states RUN, DRAIN, FETCH, HOLD.
REQ-019 In RUN SHALL pass cpu_* straight to mem_* (combinational mux) with cpu_grant=1.
REQ-020 On finish_pulse in RUN SHALL go to DRAIN; if cpu_mem_write=1 that cycle, the write SHALL still reach memory.
REQ-021 In DRAIN SHALL keep cpu_grant=1 while cpu_mem_write=1; on first cycle with cpu_mem_write=0 SHALL drop cpu_grant and enter FETCH with disp_addr=BASE_ADDR.
REQ-022 With cpu_grant=0, mem_write SHALL be 0 and CPU strobes SHALL be ignored.
REQ-023 In FETCH SHALL drive mem_read=1, mem_addr=disp_addr for exactly one cycle, capture mem_rdata[15:0] into disp_word, set disp_valid=1, clear dwell counter, enter HOLD.
REQ-024 In HOLD SHALL hold mem_read=1, mem_addr=disp_addr and increment a 16-bit dwell counter on each tick_1k.
REQ-025 When a tick_1k arrives with dwell counter = DWELL-1, SHALL set disp_addr to disp_addr+STEP (or BASE_ADDR if disp_addr=LAST_ADDR) and enter FETCH next cycle.
REQ-026 disp_word SHALL change only in FETCH; no intermediate value visible between words.
REQ-027 finish_pulse in DRAIN/FETCH/HOLD SHALL restart at BASE_ADDR via FETCH, dwell counter cleared.
REQ-028 Address arithmetic SHALL be 32-bit modulo; sequence BASE_ADDR..LAST_ADDR assumes (LAST_ADDR-BASE_ADDR) is a multiple of STEP.
REQ-029 Display mode SHALL persist until reset; no return to RUN otherwise.

Reset
REQ-030 While reset=0 at a clk edge SHALL enter RUN, cpu_grant=1, disp_word=0, disp_valid=0, disp_addr=BASE_ADDR, dwell counter=0, sync flops=0.
REQ-031 Reset mid-display SHALL return memory ownership to the CPU on the next cycle; mem_* equals cpu_* from then.

Structure
REQ-032 State encoding and BASE_ADDR/STEP/LAST_ADDR/DWELL defaults SHALL live in the shared package used by the top level.
REQ-033 SHALL contain one sub-module, finish_sync (2-flop synchroniser plus rising-edge detector).

Verification
REQ-034 Reset, CPU write addr 0x8 data 0x1234 in RUN -> mem_write=1, mem_addr=0x8, cpu_grant=1.
REQ-035 finish rises while cpu_mem_write=1 for 3 cycles -> write completes, cpu_grant drops the cycle after write falls, mem_addr=0x4.
REQ-036 mem[0x4]=0xABCD, 1000 tick_1k in HOLD -> disp_word=0xABCD, then FETCH at 0x8 after the 1000th tick.
REQ-037 disp_addr=LAST_ADDR (0x3C), DWELL ticks elapse -> next mem_addr=0x4.
REQ-038 CPU asserts mem_write during HOLD -> mem_write stays 0, memory unchanged.
REQ-039 reset=0 for one cycle during HOLD -> cpu_grant=1, disp_valid=0, disp_word=0 next cycle.
